// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: opcodes, function
// codes, ALU control values, FSM states and instruction classes.
package cu_pkg;

   localparam int OPCODE_BITS   = 6;
   localparam int FN_BITS       = 6;
   localparam int ALU_CTRL_BITS = 4;

   localparam logic [OPCODE_BITS-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_BITS-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_BITS-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_BITS-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_BITS-1:0] OP_BEQ   = 6'b000100;

   localparam logic [FN_BITS-1:0] FN_ADD = 6'b100000;
   localparam logic [FN_BITS-1:0] FN_SUB = 6'b100010;
   localparam logic [FN_BITS-1:0] FN_AND = 6'b100100;
   localparam logic [FN_BITS-1:0] FN_OR  = 6'b100101;
   localparam logic [FN_BITS-1:0] FN_SLL = 6'b000000;
   localparam logic [FN_BITS-1:0] FN_SRL = 6'b000010;

   localparam logic [ALU_CTRL_BITS-1:0] ALU_ADD = 4'b0000;
   localparam logic [ALU_CTRL_BITS-1:0] ALU_SUB = 4'b0001;
   localparam logic [ALU_CTRL_BITS-1:0] ALU_AND = 4'b0010;
   localparam logic [ALU_CTRL_BITS-1:0] ALU_OR  = 4'b0100;
   localparam logic [ALU_CTRL_BITS-1:0] ALU_SLL = 4'b1001;
   localparam logic [ALU_CTRL_BITS-1:0] ALU_SRL = 4'b1010;

   typedef enum logic [2:0] {
      ST_IDLE, ST_DECODE, ST_EXEC, ST_MEM_RD, ST_MEM_WR, ST_WB, ST_TRAP, ST_MEMERR
   } cu_state_e;

   typedef enum logic [2:0] {
      CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_ILLEGAL
   } instr_class_e;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction classifier: maps opcode/function code to an
// instruction class, ALU operation and immediate-operand select.
module cu_decoder
   import cu_pkg::*;
(
   input  logic [OPCODE_BITS-1:0]   opcode,
   input  logic [FN_BITS-1:0]       fn_code,
   output instr_class_e             instr_class,
   output logic [ALU_CTRL_BITS-1:0] alu_control,
   output logic                     alu_src_imm,
   output logic                     illegal
);

   always_comb begin
      instr_class = CLS_ILLEGAL;
      alu_control = ALU_ADD;
      alu_src_imm = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            instr_class = CLS_R;
            case (fn_code)
               FN_ADD:  alu_control = ALU_ADD;
               FN_SUB:  alu_control = ALU_SUB;
               FN_AND:  alu_control = ALU_AND;
               FN_OR:   alu_control = ALU_OR;
               FN_SLL:  alu_control = ALU_SLL;
               FN_SRL:  alu_control = ALU_SRL;
               default: instr_class = CLS_ILLEGAL;
            endcase
         end
         OP_ADDI: begin
            instr_class = CLS_ADDI;
            alu_src_imm = 1'b1;
         end
         OP_LW: begin
            instr_class = CLS_LW;
            alu_src_imm = 1'b1;
         end
         OP_SW: begin
            instr_class = CLS_SW;
            alu_src_imm = 1'b1;
         end
         OP_BEQ: begin
            instr_class = CLS_BEQ;
            alu_control = ALU_SUB;
         end
         default: instr_class = CLS_ILLEGAL;
      endcase
      illegal = (instr_class == CLS_ILLEGAL);
   end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle main control unit: accepts one instruction per valid/ready handshake
// and sequences DECODE/EXEC/MEM/WB, trapping illegal opcodes and memory timeouts.
module multicycle_cu
   import cu_pkg::*;
#(
   parameter int OPCODE_W    = 6,
   parameter int FN_W        = 6,
   parameter int ALU_CTRL_W  = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [OPCODE_W-1:0]   opcode,
   input  logic [FN_W-1:0]       fn_code,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  reg_write,
   output logic                  alu_to_reg,
   output logic                  alu_src_imm,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  pc_write,
   output logic                  branch_taken,
   output logic                  illegal,
   output logic                  mem_error,
   output cu_state_e             fsm_state
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   // Handshake: an instruction transfers on any rising edge where
   // instr_valid && instr_ready; fields are only captured on that edge.
   cu_state_e               state, state_nxt;
   logic [OPCODE_W-1:0]     op_q;
   logic [FN_W-1:0]         fn_q;
   logic [CNT_W-1:0]        wait_cnt;
   logic                    accept, in_mem, mem_timeout;
   instr_class_e            cls;
   logic [ALU_CTRL_W-1:0]   dec_alu;
   logic                    dec_imm, dec_illegal;

   cu_decoder u_decoder (
      .opcode      (op_q),
      .fn_code     (fn_q),
      .instr_class (cls),
      .alu_control (dec_alu),
      .alu_src_imm (dec_imm),
      .illegal     (dec_illegal)
   );

   assign accept      = instr_valid && instr_ready;
   assign in_mem      = (state == ST_MEM_RD) || (state == ST_MEM_WR);
   assign mem_timeout = (wait_cnt == CNT_LAST);
   assign fsm_state   = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         op_q     <= '0;
         fn_q     <= '0;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q <= opcode;
            fn_q <= fn_code;
         end
         // Counts cycles spent in a memory state; stops at CNT_LAST since the FSM leaves then.
         wait_cnt <= (in_mem && state_nxt == state) ? wait_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_nxt    = state;
      instr_ready  = 1'b0;
      reg_write    = 1'b0;
      alu_to_reg   = 1'b0;
      alu_src_imm  = 1'b0;
      alu_control  = '0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      pc_write     = 1'b0;
      branch_taken = 1'b0;
      illegal      = 1'b0;
      mem_error    = 1'b0;
      case (state)
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_nxt = ST_DECODE;
         end
         ST_DECODE: state_nxt = dec_illegal ? ST_TRAP : ST_EXEC;
         ST_EXEC: begin
            alu_control = dec_alu;
            alu_src_imm = dec_imm;
            case (cls)
               CLS_LW:  state_nxt = ST_MEM_RD;
               CLS_SW:  state_nxt = ST_MEM_WR;
               CLS_BEQ: begin
                  pc_write     = 1'b1;
                  branch_taken = zero;
                  state_nxt    = ST_IDLE;
               end
               default: state_nxt = ST_WB;
            endcase
         end
         ST_MEM_RD: begin
            mem_read    = 1'b1;
            alu_control = dec_alu;
            alu_src_imm = dec_imm;
            if (mem_ready)        state_nxt = ST_WB;
            else if (mem_timeout) state_nxt = ST_MEMERR;
         end
         ST_MEM_WR: begin
            mem_write   = 1'b1;
            alu_control = dec_alu;
            alu_src_imm = dec_imm;
            if (mem_ready) begin
               pc_write  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (mem_timeout) begin
               state_nxt = ST_MEMERR;
            end
         end
         ST_WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            alu_to_reg = (cls != CLS_LW);
            state_nxt  = ST_IDLE;
         end
         ST_TRAP: begin
            illegal   = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_MEMERR: begin
            mem_error = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu: per-cycle output traces predicted from the
// instruction timeline, randomized instructions, memory waits and busy-time noise.
module tb_multicycle_cu;
   import cu_pkg::*;

   localparam int MEM_TIMEOUT = 15;
   localparam int VW = 14;

   typedef struct packed {
      logic       rdy, rw, a2r, imm;
      logic [3:0] alu;
      logic       mr, mw, pcw, bt, ill, merr;
   } outv_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] fn_code = '0;
   logic       instr_ready, reg_write, alu_to_reg, alu_src_imm;
   logic [3:0] alu_control;
   logic       mem_read, mem_write, pc_write, branch_taken, illegal, mem_error;
   cu_state_e  fsm_state;

   logic [VW-1:0] obs;
   logic [VW-1:0] exp_q[$];
   outv_t         idle_vec;
   int            n_checks = 0;
   int            n_pass = 0;

   always #5 clk = ~clk;

   multicycle_cu #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .fn_code(fn_code), .zero(zero), .mem_ready(mem_ready),
      .reg_write(reg_write), .alu_to_reg(alu_to_reg), .alu_src_imm(alu_src_imm),
      .alu_control(alu_control), .mem_read(mem_read), .mem_write(mem_write),
      .pc_write(pc_write), .branch_taken(branch_taken), .illegal(illegal),
      .mem_error(mem_error), .fsm_state(fsm_state)
   );

   assign obs = {instr_ready, reg_write, alu_to_reg, alu_src_imm, alu_control,
                 mem_read, mem_write, pc_write, branch_taken, illegal, mem_error};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, want);
   endtask

   // Expected outputs for cycles 1..N after the accept edge; cycle N+1 is idle again.
   // kind: 0 = ALU writeback, 1 = load, 2 = store, 3 = branch, 4 = illegal.
   task automatic build_trace(input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input int waits);
      int kind, mem_n;
      logic [3:0] alu;
      logic imm, ok;
      outv_t v;
      kind = 4; alu = 4'd0; imm = 1'b0;
      if (op == 6'h00) begin
         kind = 0;
         case (fn)
            6'h20: alu = 4'd0;
            6'h22: alu = 4'd1;
            6'h24: alu = 4'd2;
            6'h25: alu = 4'd4;
            6'h00: alu = 4'd9;
            6'h02: alu = 4'd10;
            default: kind = 4;
         endcase
      end else if (op == 6'h08) begin kind = 0; imm = 1'b1; end
      else if (op == 6'h23)   begin kind = 1; imm = 1'b1; end
      else if (op == 6'h2b)   begin kind = 2; imm = 1'b1; end
      else if (op == 6'h04)   begin kind = 3; alu = 4'd1; end
      v = '0;
      exp_q.push_back(v);
      if (kind == 4) begin
         v = '0; v.ill = 1'b1;
         exp_q.push_back(v);
      end else begin
         v = '0; v.imm = imm; v.alu = alu;
         v.pcw = (kind == 3); v.bt = (kind == 3) && z;
         exp_q.push_back(v);
         if (kind == 0) begin
            v = '0; v.rw = 1'b1; v.pcw = 1'b1; v.a2r = 1'b1;
            exp_q.push_back(v);
         end else if (kind == 1 || kind == 2) begin
            ok = (waits < MEM_TIMEOUT);
            mem_n = ok ? waits + 1 : MEM_TIMEOUT;
            for (int m = 1; m <= mem_n; m++) begin
               v = '0; v.imm = imm; v.alu = alu;
               v.mr = (kind == 1); v.mw = (kind == 2);
               v.pcw = (kind == 2) && ok && (m == mem_n);
               exp_q.push_back(v);
            end
            v = '0;
            if (!ok) begin
               v.merr = 1'b1;
               exp_q.push_back(v);
            end else if (kind == 1) begin
               v.rw = 1'b1; v.pcw = 1'b1;
               exp_q.push_back(v);
            end
         end
      end
   endtask

   // waits: memory cycles with mem_ready low before it rises (>= MEM_TIMEOUT: never).
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int waits, input string tag);
      int n;
      exp_q.delete();
      build_trace(op, fn, z, waits);
      n = exp_q.size();
      @(posedge clk); #1;
      instr_valid = 1'b1; opcode = op; fn_code = fn;
      zero = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq({tag, " idle"}, obs, idle_vec);
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #1;
         instr_valid = 1'($urandom_range(0, 1));
         opcode = 6'($urandom); fn_code = 6'($urandom);
         zero = (c == 2) ? z : 1'($urandom_range(0, 1));
         mem_ready = (c >= 3) ? ((c - 3) >= waits) : 1'($urandom_range(0, 1));
         @(negedge clk);
         check_eq($sformatf("%s c%0d", tag, c), obs, exp_q.pop_front());
      end
   endtask

   task automatic reset_mid_load();
      @(posedge clk); #1;
      instr_valid = 1'b1; opcode = 6'h23; fn_code = 6'h00; mem_ready = 1'b0;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_eq("pre_reset mem_read", {31'd0, mem_read}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("async reset outputs", obs, idle_vec);
      check_eq("async reset state", fsm_state, ST_IDLE);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_eq($sformatf("post_reset c%0d", i), obs, idle_vec);
      end
   endtask

   initial begin
      logic [5:0] op_pool [8];
      logic [5:0] fn_pool [7];
      idle_vec = '0;
      idle_vec.rdy = 1'b1;
      op_pool = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h3f};
      fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2a};

      repeat (2) @(negedge clk);
      check_eq("reset outputs", obs, idle_vec);
      check_eq("reset state", fsm_state, ST_IDLE);
      rst_n = 1'b1;

      run_instr(6'h00, 6'h20, 1'b0, 0, "add");
      run_instr(6'h00, 6'h22, 1'b1, 0, "sub");
      run_instr(6'h00, 6'h24, 1'b0, 0, "and");
      run_instr(6'h00, 6'h25, 1'b0, 0, "or");
      run_instr(6'h00, 6'h00, 1'b0, 0, "sll");
      run_instr(6'h00, 6'h02, 1'b0, 0, "srl");
      run_instr(6'h08, 6'h15, 1'b0, 0, "addi");
      run_instr(6'h23, 6'h00, 1'b0, 3, "lw_w3");
      run_instr(6'h2b, 6'h00, 1'b0, 0, "sw_w0");
      run_instr(6'h04, 6'h00, 1'b1, 0, "beq_z1");
      run_instr(6'h04, 6'h00, 1'b0, 0, "beq_z0");
      run_instr(6'h3f, 6'h20, 1'b0, 0, "ill_op");
      run_instr(6'h00, 6'h2a, 1'b0, 0, "ill_fn");
      run_instr(6'h23, 6'h00, 1'b0, 40, "lw_timeout");
      run_instr(6'h23, 6'h00, 1'b0, MEM_TIMEOUT - 1, "lw_last");
      run_instr(6'h2b, 6'h00, 1'b0, 40, "sw_timeout");
      run_instr(6'h2b, 6'h00, 1'b0, MEM_TIMEOUT - 1, "sw_last");

      reset_mid_load();

      for (int i = 0; i < 40; i++) begin
         logic [5:0] op, fn;
         op = op_pool[$urandom_range(0, 7)];
         fn = fn_pool[$urandom_range(0, 6)];
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
         run_instr(op, fn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 17)),
                   $sformatf("rnd%0d", i));
      end

      @(posedge clk); #1;
      instr_valid = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
